// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | instr_fetch_unit_if
// | Fetch-stage bundle: control, memory read port, execute handshake, status.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        run;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  instr_opcode;
  logic [11:0] instr_operand;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [15:0] pc;
  logic        halted;
  logic        pc_wrap_err;

  modport master (
    input  run, mem_data, instr_ready, redirect, redirect_addr,
    output mem_addr, mem_rd, instr_valid, instr, instr_opcode, instr_operand,
           instr_pc, pc, halted, pc_wrap_err
  );

  modport slave (
    output run, mem_data, instr_ready, redirect, redirect_addr,
    input  mem_addr, mem_rd, instr_valid, instr, instr_opcode, instr_operand,
           instr_pc, pc, halted, pc_wrap_err
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | instr_fetch_unit
// | Fetch stage: PC-driven memory reads, one-cycle read latency, valid/ready
// | hand-off to execute, jump redirects and HALT. Optional macro
// | IFU_PC_WRAP_ERR_EN flags a PC wrap past 16'hFFFF and halts on it.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'b0111
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

`ifdef IFU_PC_WRAP_ERR_EN
  localparam logic c_WRAP_EN = 1'b1;
`else
  localparam logic c_WRAP_EN = 1'b0;
`endif

  state_t      r_state, w_state_nxt, w_resume;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_instr_pc, w_instr_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_wrap_err, w_wrap_err_nxt;
  logic        w_hs;

  assign w_hs     = r_valid & bus.instr_ready;
  assign w_resume = bus.run ? S_ADDR : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 16'h0000;
      r_instr_pc <= 16'h0000;
      r_valid    <= 1'b0;
      r_wrap_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_wrap_err <= w_wrap_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_wrap_err_nxt = r_wrap_err;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect)
          w_pc_nxt = bus.redirect_addr;
        else if (bus.run)
          w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (bus.redirect) begin
          w_pc_nxt    = bus.redirect_addr;
          w_state_nxt = w_resume;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect here drops the word the memory is returning this cycle.
        if (bus.redirect) begin
          w_pc_nxt    = bus.redirect_addr;
          w_state_nxt = w_resume;
        end else begin
          w_instr_nxt    = bus.mem_data;
          w_instr_pc_nxt = r_pc;
          w_pc_nxt       = r_pc + 16'd1;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_HOLD;
          if (c_WRAP_EN && (r_pc == 16'hFFFF))
            w_wrap_err_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_hs) begin
          w_valid_nxt = 1'b0;
          if (bus.redirect)
            w_pc_nxt = bus.redirect_addr;
          if ((r_instr[15:12] == HALT_OPCODE) || r_wrap_err)
            w_state_nxt = S_HALTED;
          else
            w_state_nxt = w_resume;
        end else if (bus.redirect) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = bus.redirect_addr;
          w_state_nxt = w_resume;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.mem_addr      = r_pc;
  assign bus.pc            = r_pc;
  assign bus.mem_rd        = (r_state == S_ADDR);
  assign bus.instr_valid   = r_valid;
  assign bus.instr         = r_instr;
  assign bus.instr_opcode  = r_instr[15:12];
  assign bus.instr_operand = r_instr[11:0];
  assign bus.instr_pc      = r_instr_pc;
  assign bus.halted        = (r_state == S_HALTED);
  assign bus.pc_wrap_err   = r_wrap_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_instr_fetch_unit
// | Scoreboard bench: expected words queued at stimulus, checked on handshake.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] ipc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem [0:255];
  exp_t        q[$];
  exp_t        e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          ta, tv1, tv2;

  instr_fetch_unit_if u_if ();

  instr_fetch_unit u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (u_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory: data for the address sampled during ADDR.
  always @(posedge clk) begin
    if (u_if.mem_rd)
      u_if.mem_data <= mem[u_if.mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic push(input logic [15:0] ins, input logic [15:0] a);
    exp_t x;
    x.instr = ins;
    x.ipc   = a;
    q.push_back(x);
  endtask

  // Samples at posedge+1 until instr_valid, bounded.
  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!u_if.instr_valid && n < 40);
    chk(tag, {31'd0, u_if.instr_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && u_if.instr_valid && u_if.instr_ready) begin
      if (q.size() == 0) begin
        chk("extra_delivery", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("instr",   {16'd0, u_if.instr},         {16'd0, e.instr});
        chk("ipc",     {16'd0, u_if.instr_pc},      {16'd0, e.ipc});
        chk("opcode",  {28'd0, u_if.instr_opcode},  {28'd0, e.instr[15:12]});
        chk("operand", {20'd0, u_if.instr_operand}, {20'd0, e.instr[11:0]});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1005;
    mem[8'h01] = 16'h2006;
    mem[8'h02] = 16'h0123;
    mem[8'h03] = 16'h7000;
    mem[8'h40] = 16'hA040;
    mem[8'h80] = 16'hB080;
    mem[8'h81] = 16'h7000;
    mem[8'hFF] = 16'h1FFF;
    u_if.mem_data      = 16'h0000;
    u_if.run           = 1'b0;
    u_if.instr_ready   = 1'b0;
    u_if.redirect      = 1'b0;
    u_if.redirect_addr = 16'h0000;
    rst_n              = 1'b0;
    #1;
    chk("rst_pc",    {16'd0, u_if.pc},       32'd0);
    chk("rst_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("rst_rd",    {31'd0, u_if.mem_rd},   32'd0);
    chk("rst_halt",  {31'd0, u_if.halted},   32'd0);
    chk("rst_wrap",  {31'd0, u_if.pc_wrap_err}, 32'd0);
    chk("rst_instr", {u_if.instr, u_if.instr_pc}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back fetch: latency and throughput
    push(16'h1005, 16'h0000);
    push(16'h2006, 16'h0001);
    u_if.run = 1'b1;
    u_if.instr_ready = 1'b1;
    ta = 0;
    for (int n = 0; n < 10 && !u_if.mem_rd; n++) begin
      @(posedge clk); #1;
    end
    chk("addr_rd", {31'd0, u_if.mem_rd}, 32'd1);
    ta = cyc;
    wait_valid("v1_timeout");
    tv1 = cyc;
    chk("latency", 32'(tv1 - ta), 32'd2);
    chk("pc_after1", {16'd0, u_if.pc}, 32'd1);
    @(posedge clk); #1;
    wait_valid("v2_timeout");
    tv2 = cyc;
    chk("throughput", 32'(tv2 - tv1), 32'd3);
    chk("pc_after2", {16'd0, u_if.pc}, 32'd2);

    // Stall the second word for five cycles
    u_if.instr_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_word", {u_if.instr, u_if.instr_pc}, {16'h2006, 16'h0001});
      chk("stall_ctl", {28'd0, u_if.instr_valid, u_if.mem_rd, 2'b00}, 32'h8);
      chk("stall_pc", {16'd0, u_if.pc}, 32'd2);
    end
    u_if.instr_ready = 1'b1;
    u_if.run = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("idle_valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("idle_pc", {16'd0, u_if.pc}, 32'd2);

    // Redirect during WAIT discards mem[2]
    push(16'hA040, 16'h0040);
    u_if.run = 1'b1;
    for (int n = 0; n < 10 && !u_if.mem_rd; n++) begin
      @(posedge clk); #1;
    end
    chk("addr_rd2", {31'd0, u_if.mem_rd}, 32'd1);
    @(posedge clk); #1;
    u_if.redirect = 1'b1;
    u_if.redirect_addr = 16'h0040;
    @(posedge clk); #1;
    u_if.redirect = 1'b0;
    chk("redir_pc", {16'd0, u_if.pc}, 32'h40);
    wait_valid("v3_timeout");
    chk("pc_after_redir", {16'd0, u_if.pc}, 32'h41);

    // Redirect on the handshake edge
    push(16'hB080, 16'h0080);
    u_if.redirect = 1'b1;
    u_if.redirect_addr = 16'h0080;
    @(posedge clk); #1;
    u_if.redirect = 1'b0;
    chk("hs_redir_pc", {16'd0, u_if.pc}, 32'h80);
    wait_valid("v4_timeout");
    chk("pc_0x81", {16'd0, u_if.pc}, 32'h81);

    // HALT at 0x81
    push(16'h7000, 16'h0081);
    for (int n = 0; n < 20 && !u_if.halted; n++) begin
      @(posedge clk); #1;
    end
    chk("halted", {31'd0, u_if.halted}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      u_if.redirect = (i == 5);
      u_if.redirect_addr = 16'h0010;
      @(posedge clk); #1;
      chk("halt_state", {30'd0, u_if.halted, u_if.mem_rd}, 32'd2);
    end
    u_if.redirect = 1'b0;
    chk("halt_pc", {16'd0, u_if.pc}, 32'h82);
    u_if.run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_halt", {31'd0, u_if.halted}, 32'd0);
    chk("rst2_pc", {16'd0, u_if.pc}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // PC wrap
    u_if.redirect = 1'b1;
    u_if.redirect_addr = 16'hFFFF;
    @(posedge clk); #1;
    u_if.redirect = 1'b0;
    chk("pc_ffff", {16'd0, u_if.pc}, 32'hFFFF);
    chk("idle_rd", {31'd0, u_if.mem_rd}, 32'd0);
    push(16'h1FFF, 16'hFFFF);
`ifndef IFU_PC_WRAP_ERR_EN
    push(16'h1005, 16'h0000);
`endif
    u_if.run = 1'b1;
    wait_valid("v5_timeout");
    chk("pc_wrapped", {16'd0, u_if.pc}, 32'd0);
`ifdef IFU_PC_WRAP_ERR_EN
    chk("wrap_err", {31'd0, u_if.pc_wrap_err}, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("wrap_halted", {31'd0, u_if.halted}, 32'd1);
`else
    chk("wrap_err", {31'd0, u_if.pc_wrap_err}, 32'd0);
    @(posedge clk); #1;
    wait_valid("v6_timeout");
    u_if.run = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("wrap_halted", {31'd0, u_if.halted}, 32'd0);
`endif
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the accumulator computer. Sits upstream of the instruction register / decode path and the ALU, and downstream of the program counter.
- Drives main-memory read addresses from its internal PC and absorbs the memory's one-cycle registered read latency.
- Captures each instruction word, splits it into opcode/operand, and hands it to the execute stage over a valid/ready handshake.
- Accepts jump redirects from execute and stops on the HALT opcode.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'b0111, opcode that stops fetching once consumed.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable from top-level control.
- mem_addr  out  16  main-memory address; equals pc in every state.
- mem_rd  out  1  read strobe to memory arbiter; memory write_enable must be 0 when this is high.
- mem_data  in  16  main-memory data_out, registered by memory.
- instr_valid  out  1  instr/opcode/operand/instr_pc are valid.
- instr_ready  in  1  execute stage accepts the instruction.
- instr  out  16  fetched instruction word.
- instr_opcode  out  4  instr[15:12].
- instr_operand  out  12  instr[11:0].
- instr_pc  out  16  address the instruction was fetched from.
- redirect  in  1  jump request, single-cycle pulse.
- redirect_addr  in  16  jump target.
- pc  out  16  next fetch address.
- halted  out  1  high in HALTED state.
- pc_wrap_err  out  1  sticky PC-wrap error (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0, instr_pc=0.
  - instr_valid=0, mem_rd=0, halted=0, pc_wrap_err=0.
  - Reset asserted mid-fetch abandons the fetch immediately; no partial state survives.
- States: IDLE, ADDR, WAIT, HOLD, HALTED. All outputs are registered or decoded from state only.
- IDLE:
  - mem_rd=0.
  - If run=1, go to ADDR next cycle.
- ADDR:
  - mem_rd=1, mem_addr=pc; memory samples on the closing edge.
  - Go to WAIT.
- WAIT:
  - mem_data holds mem[pc].
  - On the closing edge: instr<=mem_data, instr_pc<=pc, pc<=pc+1 (16-bit, 16'hFFFF wraps to 16'h0000), instr_valid<=1.
  - Go to HOLD.
- HOLD:
  - instr_valid=1; instr, instr_opcode, instr_operand and instr_pc are held stable until the handshake.
  - Handshake = instr_valid & instr_ready at a rising edge; on it, instr_valid<=0.
  - If the consumed opcode == HALT_OPCODE, go to HALTED.
  - Else, if run=1, go to ADDR; if run=0, go to IDLE.
- Timing:
  - Latency from ADDR entry to instr_valid=1 is 2 cycles.
  - Peak throughput is 1 instruction per 3 cycles with instr_ready held high.
- run deasserted during ADDR/WAIT: the fetch completes and the instruction is still presented; IDLE is entered after the handshake.
- redirect=1 (highest priority over the normal next-state):
  - ADDR/WAIT: in-flight fetch discarded, pc<=redirect_addr, next state ADDR (IDLE if run=0).
  - HOLD without handshake that cycle: instruction flushed (instr_valid<=0), pc<=redirect_addr, next state ADDR/IDLE by run.
  - HOLD with handshake in the same cycle: the instruction counts as consumed; pc<=redirect_addr; HALT check still applies.
  - IDLE: pc<=redirect_addr, stay IDLE.
  - HALTED: ignored.
- HALTED: mem_rd=0, halted=1, pc frozen. Exit only via reset.
- mem_addr upper bits beyond the memory depth (16Ki words) are passed through; memory ignores them.

Optional Feature:
- Macro: IFU_PC_WRAP_ERR_EN.
- Defined: a WAIT-state capture with pc==16'hFFFF still presents that instruction, then:
  - pc_wrap_err<=1 (sticky until reset);
  - after the handshake the FSM goes to HALTED instead of fetching address 0.
- Undefined: pc wraps silently to 16'h0000 and pc_wrap_err is tied 0.

Test Plan:
- Reset, mem[0]=16'h1005, mem[1]=16'h2006, run=1, instr_ready=1 -> instr_valid high with instr=16'h1005, opcode=4'h1, operand=12'h005, instr_pc=0, two cycles after ADDR entry; next instr=16'h2006 three cycles later; pc=2.
- instr_ready=0 for 5 cycles while instr_valid=1 -> outputs stable, mem_rd=0, pc unchanged; single handshake on ready, no duplicate delivery.
- redirect=1, redirect_addr=16'h0040 during WAIT -> the discarded word never appears on instr; next delivered instr_pc=16'h0040; pc=16'h0041 after capture.
- Redirect on the same edge as the HOLD handshake -> the instruction is consumed once; next fetch is from redirect_addr.
- mem[3]=16'h7000 -> after the handshake halted=1, mem_rd stays 0 for 20 cycles, redirect ignored; reset low clears halted and pc=RESET_PC.
- pc forced to 16'hFFFF via redirect -> with IFU_PC_WRAP_ERR_EN: pc_wrap_err=1, HALTED after the handshake; without it: next instr_pc=16'h0000.
